// File: rtl/prior_buffer_ctrl.sv
// First-hit priority selector over a programmable search window, driving buffer init/enable/done strobes.
// Optional hit counter output enabled by defining PRIOR_BUFFER_CTRL_HITCNT_EN.
module prior_buffer_ctrl #(
    parameter int LANES = 4,
    parameter int LEN_W = 10,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             in_ctr_Srst_n,
    input  logic             in_ctr_en,
    input  logic             in_start,
    input  logic [LEN_W-1:0] in_len,
    input  logic [LANES-1:0] in_hit,
    output logic             out_ctr_init,
    output logic             out_ctr_buf_en,
    output logic             out_ctr_valid,
    output logic             out_ctr_done,
    output logic [SEL_W-1:0] out_sel_lane,
    output logic [LEN_W-1:0] out_sel_cycle,
    output logic             out_busy,
    output logic             out_found
`ifdef PRIOR_BUFFER_CTRL_HITCNT_EN
    ,
    output logic [LEN_W+SEL_W:0] out_hit_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SEARCH,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [SEL_W-1:0] hit_lane;
    logic             hit_any;
    logic             active;

    // Strobes are gated by reset and enable so they drop immediately, not one cycle later.
    assign active         = in_ctr_Srst_n && in_ctr_en;
    assign hit_any        = |in_hit;
    assign out_busy       = (state != IDLE);
    assign out_ctr_init   = active && (state == INIT);
    assign out_ctr_buf_en = active && ((state == SEARCH) || (state == DONE));
    assign out_ctr_done   = active && (state == DONE);
    assign out_ctr_valid  = active && (state == SEARCH) && !out_found && hit_any;

    always_comb begin
        logic got;
        got      = 1'b0;
        hit_lane = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_hit[i] && !got) begin
                hit_lane = SEL_W'(i);
                got      = 1'b1;
            end
        end
    end

`ifdef PRIOR_BUFFER_CTRL_HITCNT_EN
    localparam int HC_W = LEN_W + SEL_W + 1;

    logic [HC_W-1:0] pop;
    logic [HC_W:0]   hc_sum;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            pop = pop + HC_W'(in_hit[i]);
        end
        hc_sum = {1'b0, out_hit_cnt} + {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            out_hit_cnt <= '0;
        end else if (in_ctr_en) begin
            if ((state == IDLE) && in_start) begin
                out_hit_cnt <= '0;
            end else if (state == SEARCH) begin
                out_hit_cnt <= hc_sum[HC_W] ? '1 : hc_sum[HC_W-1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            state         <= IDLE;
            len_q         <= '0;
            cnt           <= '0;
            out_sel_lane  <= '0;
            out_sel_cycle <= '0;
            out_found     <= 1'b0;
        end else if (in_ctr_en) begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        state         <= INIT;
                        len_q         <= in_len;
                        cnt           <= '0;
                        out_sel_lane  <= '0;
                        out_sel_cycle <= '0;
                        out_found     <= 1'b0;
                    end
                end
                INIT: begin
                    state <= (len_q == '0) ? DONE : SEARCH;
                end
                SEARCH: begin
                    if (out_ctr_valid) begin
                        out_sel_lane  <= hit_lane;
                        out_sel_cycle <= cnt;
                        out_found     <= 1'b1;
                    end
                    if (cnt == (len_q - LEN_W'(1))) begin
                        state <= DONE;
                    end
                    cnt <= cnt + LEN_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prior_buffer_ctrl.sv
// Directed bench for prior_buffer_ctrl: frames are modelled at stimulus time and checked against a scoreboard on done.
module tb_prior_buffer_ctrl;

    localparam int LANES = 4;
    localparam int LEN_W = 10;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             in_ctr_Srst_n;
    logic             in_ctr_en;
    logic             in_start;
    logic [LEN_W-1:0] in_len;
    logic [LANES-1:0] in_hit;
    logic             out_ctr_init;
    logic             out_ctr_buf_en;
    logic             out_ctr_valid;
    logic             out_ctr_done;
    logic [SEL_W-1:0] out_sel_lane;
    logic [LEN_W-1:0] out_sel_cycle;
    logic             out_busy;
    logic             out_found;
`ifdef PRIOR_BUFFER_CTRL_HITCNT_EN
    logic [LEN_W+SEL_W:0] out_hit_cnt;
`endif

    prior_buffer_ctrl #(.LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .in_ctr_Srst_n (in_ctr_Srst_n),
        .in_ctr_en     (in_ctr_en),
        .in_start      (in_start),
        .in_len        (in_len),
        .in_hit        (in_hit),
        .out_ctr_init  (out_ctr_init),
        .out_ctr_buf_en(out_ctr_buf_en),
        .out_ctr_valid (out_ctr_valid),
        .out_ctr_done  (out_ctr_done),
        .out_sel_lane  (out_sel_lane),
        .out_sel_cycle (out_sel_cycle),
        .out_busy      (out_busy),
        .out_found     (out_found)
`ifdef PRIOR_BUFFER_CTRL_HITCNT_EN
        ,
        .out_hit_cnt   (out_hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             found;
        logic [SEL_W-1:0] lane;
        logic [LEN_W-1:0] cyc;
        int               nvalid;
        int               nbuf;
        int               ninit;
        int               nact;
        int               hc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   total_done = 0;
    int   frames = 0;
    int   n_init, n_buf, n_valid, n_act;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (in_ctr_Srst_n && in_ctr_en && in_start && !out_busy) begin
            n_init = 0; n_buf = 0; n_valid = 0; n_act = 0;
        end
        if (!in_ctr_Srst_n || !in_ctr_en || !out_busy)
            chk("strobes_quiet", {28'd0, out_ctr_init, out_ctr_buf_en, out_ctr_valid, out_ctr_done}, 32'd0);
        if (in_ctr_Srst_n && in_ctr_en) begin
            n_init  += int'(out_ctr_init);
            n_buf   += int'(out_ctr_buf_en);
            n_valid += int'(out_ctr_valid);
            if (out_busy) n_act++;
        end
        if (out_ctr_done) begin
            total_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("found", {31'd0, out_found}, {31'd0, e.found});
                chk("sel_lane", {30'd0, out_sel_lane}, {30'd0, e.lane});
                chk("sel_cycle", {22'd0, out_sel_cycle}, {22'd0, e.cyc});
                chk("n_valid", n_valid, e.nvalid);
                chk("n_buf_en", n_buf, e.nbuf);
                chk("n_init", n_init, e.ninit);
                chk("n_active", n_act, e.nact);
`ifdef PRIOR_BUFFER_CTRL_HITCNT_EN
                chk("hit_cnt", 32'(out_hit_cnt), e.hc);
`endif
            end
        end
    end

    function automatic logic [LANES-1:0] hit_at(input int s, input logic [LANES-1:0] base,
                                                input int c1, input logic [LANES-1:0] h1,
                                                input int c2, input logic [LANES-1:0] h2);
        return (s == c1) ? h1 : (s == c2) ? h2 : base;
    endfunction

    // s = -1 is the INIT cycle, 0..len-1 the search cycles, len the DONE cycle.
    task automatic frame(input int len, input logic [LANES-1:0] base,
                         input int c1, input logic [LANES-1:0] h1,
                         input int c2, input logic [LANES-1:0] h2,
                         input int fz_at, input int fz_n, input bit busy_start);
        exp_t e;
        logic [LANES-1:0] h;
        int k;
        e.found = 1'b0; e.lane = '0; e.cyc = '0; e.hc = 0;
        for (int s = 0; s < len; s++) begin
            h = hit_at(s, base, c1, h1, c2, h2);
            e.hc += $countones(h);
            if (!e.found && h != '0) begin
                e.found = 1'b1;
                e.cyc   = LEN_W'(s);
                for (int b = LANES - 1; b >= 0; b--)
                    if (h[b]) e.lane = SEL_W'(b);
            end
        end
        e.nvalid = e.found ? 1 : 0;
        e.nbuf   = len + 1;
        e.ninit  = 1;
        e.nact   = len + 2;
        sb.push_back(e);
        frames++;
        @(negedge clk);
        in_start = 1'b1;
        in_len   = LEN_W'(len);
        in_hit   = '0;
        for (int s = -1; s <= len; s++) begin
            @(negedge clk);
            in_start = 1'b0;
            if (s == fz_at) begin
                for (int f = 0; f < fz_n; f++) begin
                    in_ctr_en = 1'b0;
                    in_hit    = '1;
                    @(negedge clk);
                end
                in_ctr_en = 1'b1;
            end
            in_hit = hit_at(s, base, c1, h1, c2, h2);
            if (busy_start && s == 1) begin
                in_start = 1'b1;
                in_len   = 10'd7;
            end
        end
        @(negedge clk);
        in_hit = '0; in_start = 1'b0; in_len = '0;
        k = 0;
        while (out_busy && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("back_to_idle", {31'd0, out_busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        in_ctr_Srst_n = 1'b0;
        in_ctr_en     = 1'b1;
        in_start      = 1'b0;
        in_len        = '0;
        in_hit        = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_state", {18'd0, out_busy, out_found, out_sel_lane, out_sel_cycle}, 32'd0);
        @(negedge clk);
        in_ctr_Srst_n = 1'b1;

        frame(5, 4'b0000, 2, 4'b0110, -100, 4'b0, -100, 0, 1'b0);
        repeat (3) @(negedge clk);
        #4;
        chk("hold_found", {31'd0, out_found}, 32'd1);
        chk("hold_lane", {30'd0, out_sel_lane}, 32'd1);
        chk("hold_cycle", {22'd0, out_sel_cycle}, 32'd2);

        frame(3, 4'b0000, -1, 4'b1111, 3, 4'b1111, -100, 0, 1'b0);
        frame(0, 4'b0000, -1, 4'b1111, 0, 4'b1111, -100, 0, 1'b0);
        frame(6, 4'b0000, 3, 4'b1000, -100, 4'b0, 2, 4, 1'b0);
        frame(4, 4'b0000, 0, 4'b1000, 1, 4'b0001, -100, 0, 1'b0);
        frame(3, 4'b0000, 2, 4'b0011, -100, 4'b0, -100, 0, 1'b1);
        frame(2, 4'b0000, 1, 4'b0100, -100, 4'b0, -100, 0, 1'b0);

        d0 = total_done;
        @(negedge clk); in_start = 1'b1; in_len = 10'd5;
        @(negedge clk); in_start = 1'b0;
        @(negedge clk); in_hit = 4'b0100;
        @(negedge clk); in_hit = 4'b0000; in_ctr_Srst_n = 1'b0;
        #4;
        chk("pre_reset_found", {29'd0, out_found, out_sel_lane}, {29'd0, 1'b1, 2'd2});
        @(negedge clk); in_ctr_Srst_n = 1'b1;
        #4;
        chk("post_reset_outputs",
            {14'd0, out_busy, out_found, out_sel_lane, out_sel_cycle,
             out_ctr_init, out_ctr_buf_en, out_ctr_valid, out_ctr_done}, 32'd0);
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", total_done, d0);

        frame(4, 4'b1111, -100, 4'b0, -100, 4'b0, -100, 0, 1'b0);
        frame(20, 4'b0000, 19, 4'b0100, -100, 4'b0, -100, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", total_done, frames);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
